// File: rtl/ghost_position_tracker_if.sv
// Ghost tracker bus: control-side inputs and committed-position outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the tracker samples proposals only in its CHECK cycle.
//
// master: ghost control / environment (drives proposals, map, Pac-Man pos)
// slave : ghost_position_tracker (drives x/y, move_tick, blocked, caught)
interface ghost_position_tracker_if;
    logic         run;            // enables the move-tick counter
    logic         respawn;        // one-cycle pulse, return to home tile
    logic [9:0]   next_x;         // proposed x from ghost control
    logic [8:0]   next_y;         // proposed y from ghost control
    logic [767:0] tilemap_walls;  // wall bitmap, bit = row*32 + col
    logic [9:0]   pac_x;          // Pac-Man x
    logic [8:0]   pac_y;          // Pac-Man y
    logic [9:0]   x;              // committed ghost x
    logic [8:0]   y;              // committed ghost y
    logic         move_tick;      // one-cycle pulse at each move start
    logic         blocked;        // last proposal rejected (sticky)
    logic         caught;         // ghost sits on Pac-Man (sticky)

    modport master (
        output run, respawn, next_x, next_y, tilemap_walls, pac_x, pac_y,
        input  x, y, move_tick, blocked, caught
    );

    modport slave (
        input  run, respawn, next_x, next_y, tilemap_walls, pac_x, pac_y,
        output x, y, move_tick, blocked, caught
    );
endinterface

// File: rtl/ghost_position_tracker.sv
// Ghost position register with move timing, proposal validation and capture.
// Latency: move_tick -> CHECK (same cycle) -> COMMIT -> new x/y visible next cycle.
// Backpressure: none; run=0 freezes the tick counter, an in-flight move completes.
//
// Ports: clk, reset (sync, active-high); bus (slave modport) carries run,
// respawn, next_x/next_y, tilemap_walls, pac_x/pac_y in and x, y,
// move_tick, blocked, caught out.
module ghost_position_tracker #(
    parameter int HOME_X   = 600,
    parameter int HOME_Y   = 160,
    parameter int TICK_DIV = 5000000,
    parameter int SPEED    = 20,
    parameter int BOUND_X0 = 0,
    parameter int BOUND_X1 = 620,
    parameter int BOUND_Y0 = 0,
    parameter int BOUND_Y1 = 460
) (
    input  logic                    clk,
    input  logic                    reset,
    ghost_position_tracker_if.slave bus
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [10:0] STEP = 11'(SPEED);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_HALT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [9:0]    r_x;
    logic [8:0]    r_y;
    logic [9:0]    r_cand_x;
    logic [8:0]    r_cand_y;
    logic          r_cand_ok;
    logic          r_tick;
    logic          r_blocked;
    logic          r_caught;

    // Constant divide-by-20 as a comparator chain: quotient is the number
    // of tile boundaries at or below v. Covers the full 10-bit range.
    function automatic logic [5:0] div20(input logic [9:0] v);
        logic [5:0] q;
        q = '0;
        for (int k = 1; k < 52; k++) begin
            if (v >= 10'(20 * k)) q = 6'(k);
        end
        return q;
    endfunction

    // ---------------- proposal validation (evaluated on live next_x/y) ----
    logic [5:0]         w_col;
    logic [5:0]         w_row;
    logic [9:0]         w_col_base;
    logic [9:0]         w_row_base;
    logic               w_aligned;
    logic               w_in_bounds;
    logic               w_in_map;
    logic [9:0]         w_idx;
    logic               w_wall;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_adx;
    logic signed [10:0] w_ady;
    logic               w_step_ok;
    logic               w_cand_ok;
    logic               w_hit;
    logic               w_wrap;

    assign w_col      = div20(bus.next_x);
    assign w_row      = div20({1'b0, bus.next_y});
    assign w_col_base = 10'(w_col) * 10'd20;
    assign w_row_base = 10'(w_row) * 10'd20;
    assign w_aligned  = (bus.next_x == w_col_base) && ({1'b0, bus.next_y} == w_row_base);

    assign w_in_bounds = (int'(bus.next_x) >= BOUND_X0) && (int'(bus.next_x) <= BOUND_X1) &&
                         (int'(bus.next_y) >= BOUND_Y0) && (int'(bus.next_y) <= BOUND_Y1);

    // Tiles outside the 32x24 map are treated as walls so the bitmap is
    // never indexed past its end.
    assign w_in_map = (w_col < 6'd32) && (w_row < 6'd24);
    assign w_idx    = {w_row[4:0], w_col[4:0]};
    assign w_wall   = w_in_map ? bus.tilemap_walls[w_idx] : 1'b1;

    // 11-bit signed differences: 10-bit operands cannot wrap here.
    assign w_dx  = $signed({1'b0, bus.next_x}) - $signed({1'b0, r_x});
    assign w_dy  = $signed({2'b00, bus.next_y}) - $signed({2'b00, r_y});
    assign w_adx = w_dx[10] ? -w_dx : w_dx;
    assign w_ady = w_dy[10] ? -w_dy : w_dy;

    // Stationary, or exactly one SPEED step along a single axis.
    assign w_step_ok = ((w_dx == '0) && (w_dy == '0)) ||
                       ((w_dx == '0) && (w_ady == STEP)) ||
                       ((w_dy == '0) && (w_adx == STEP));

    assign w_cand_ok = w_in_bounds && w_aligned && w_step_ok && !w_wall;

    assign w_hit  = (r_x == bus.pac_x) && (r_y == bus.pac_y);
    assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.respawn) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit)                  w_state_nxt = S_HALT;
                    else if (bus.run && w_wrap) w_state_nxt = S_CHECK;
                end
                S_CHECK:  w_state_nxt = S_COMMIT;
                S_COMMIT: w_state_nxt = w_hit ? S_HALT : S_IDLE;
                S_HALT:   w_state_nxt = S_HALT;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: control strobes ----------------
    logic w_cnt_inc;
    logic w_tick_fire;
    logic w_latch;
    logic w_commit;
    logic w_set_caught;

    always_comb begin
        w_cnt_inc    = 1'b0;
        w_tick_fire  = 1'b0;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        w_set_caught = 1'b0;
        if (!bus.respawn) begin
            case (r_state)
                S_IDLE: begin
                    // Capture wins over a tick due in the same cycle.
                    if (w_hit) begin
                        w_set_caught = 1'b1;
                    end else if (bus.run) begin
                        if (w_wrap) w_tick_fire = 1'b1;
                        else        w_cnt_inc   = 1'b1;
                    end
                end
                S_CHECK:  w_latch = 1'b1;
                S_COMMIT: begin
                    w_commit     = 1'b1;
                    w_set_caught = w_hit;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= 10'(HOME_X);
            r_y       <= 9'(HOME_Y);
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_blocked <= 1'b0;
            r_caught  <= 1'b0;
            r_cand_x  <= '0;
            r_cand_y  <= '0;
            r_cand_ok <= 1'b0;
        end else if (bus.respawn) begin
            r_x       <= 10'(HOME_X);
            r_y       <= 9'(HOME_Y);
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_blocked <= 1'b0;
            r_caught  <= 1'b0;
        end else begin
            r_tick <= w_tick_fire;
            if (w_tick_fire)    r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

            if (w_latch) begin
                r_cand_x  <= bus.next_x;
                r_cand_y  <= bus.next_y;
                r_cand_ok <= w_cand_ok;
            end

            if (w_commit) begin
                if (r_cand_ok) begin
                    r_x       <= r_cand_x;
                    r_y       <= r_cand_y;
                    r_blocked <= 1'b0;
                end else begin
                    r_blocked <= 1'b1;
                end
            end

            if (w_set_caught) r_caught <= 1'b1;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.move_tick = r_tick;
    assign bus.blocked   = r_blocked;
    assign bus.caught    = r_caught;

endmodule

// File: tb/tb_ghost_position_tracker.sv
// Bench for ghost_position_tracker with TICK_DIV=4.
// Move results go through a scoreboard queue checked by an independent monitor.
// Directed timing/flag checks run inline in the stimulus process.
module tb_ghost_position_tracker;

    logic clk;
    logic reset;

    ghost_position_tracker_if bus();

    ghost_position_tracker #(
        .HOME_X(600), .HOME_Y(160), .TICK_DIV(4), .SPEED(20),
        .BOUND_X0(0), .BOUND_X1(620), .BOUND_Y0(0), .BOUND_Y1(460)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cur_x;
    int   cur_y;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts negedges until move_tick is seen; index 0 is the next negedge.
    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.move_tick) return;
            n++;
            if (n > 40) begin
                chk("move_tick timeout", 32'd1, 32'd0);
                n = -1;
                return;
            end
        end
    endtask

    // Issue one proposal, queue its expected result, wait for its tick and
    // return at the negedge where the result is visible (cycle after COMMIT).
    task automatic do_move(input int px, input int py, input int ex, input int ey,
                           input int eb, input int exp_n, input string name,
                           input bit drop_run);
        int   n;
        exp_t e;
        bus.next_x = 10'(px);
        bus.next_y = 9'(py);
        e.x = 10'(ex);
        e.y = 9'(ey);
        e.b = 1'(eb);
        exp_q.push_back(e);
        wait_tick(n);
        if (n < 0) return;
        if (drop_run) bus.run = 1'b0;
        if (exp_n >= 0) chk({name, " tick index"}, n, exp_n);
        @(negedge clk);
        chk({name, " x held in COMMIT"}, bus.x, cur_x);
        chk({name, " y held in COMMIT"}, bus.y, cur_y);
        @(negedge clk);
        cur_x = ex;
        cur_y = ey;
    endtask

    // Monitor: every move_tick produces one result two cycles later.
    initial begin : monitor
        realtime last_t;
        exp_t    e;
        last_t = -1.0;
        forever begin
            @(negedge clk);
            if (!reset && bus.move_tick) begin
                if (last_t >= 0.0)
                    chk("tick spacing>=4", (($realtime - last_t) >= 40.0) ? 1 : 0, 1);
                last_t = $realtime;
                @(negedge clk);
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("unexpected move result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result x", bus.x, e.x);
                    chk("result y", bus.y, e.y);
                    chk("result blocked", bus.blocked, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ticks;
        int moved;
        int n;

        reset             = 1'b1;
        bus.run           = 1'b1;
        bus.respawn       = 1'b0;
        bus.next_x        = 10'd600;
        bus.next_y        = 9'd140;
        bus.tilemap_walls = '0;
        bus.pac_x         = 10'd0;
        bus.pac_y         = 9'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset x", bus.x, 600);
        chk("reset y", bus.y, 160);
        chk("reset move_tick", bus.move_tick, 0);
        chk("reset blocked", bus.blocked, 0);
        chk("reset caught", bus.caught, 0);

        step();
        reset = 1'b0;
        cur_x = 600;
        cur_y = 160;

        // First move: counter 0..3 then tick in cycle 4 after release.
        do_move(600, 140, 600, 140, 0, 4, "t1 up", 1'b0);

        // Wall at row 6 col 30 blocks (600,120); sidestep is legal.
        bus.tilemap_walls[222] = 1'b1;
        do_move(600, 120, 600, 140, 1, -1, "t2 wall", 1'b0);
        do_move(580, 140, 580, 140, 0, -1, "t2 side", 1'b0);
        do_move(600, 120, 580, 140, 1, -1, "t2 diag", 1'b0);

        // Respawn exactly in the counter==3 cycle: tick suppressed.
        step();
        step();
        step();
        bus.respawn = 1'b1;
        step();
        bus.respawn = 1'b0;
        @(negedge clk);
        chk("respawn x", bus.x, 600);
        chk("respawn y", bus.y, 160);
        chk("respawn blocked", bus.blocked, 0);
        chk("respawn tick suppressed", bus.move_tick, 0);
        cur_x = 600;
        cur_y = 160;

        // Illegal proposals from home, then legal edge cases.
        do_move(610, 160, 600, 160, 1, 3, "t3 misaligned", 1'b0);
        do_move(640, 160, 600, 160, 1, -1, "t3 out of bounds", 1'b0);
        do_move(560, 160, 600, 160, 1, -1, "t3 40px step", 1'b0);
        do_move(580, 140, 600, 160, 1, -1, "t3 diagonal", 1'b0);
        do_move(600, 160, 600, 160, 0, -1, "stationary", 1'b0);
        do_move(620, 160, 620, 160, 0, -1, "x at max bound", 1'b0);
        do_move(600, 160, 600, 160, 0, -1, "back left", 1'b0);

        // Capture.
        bus.pac_x = 10'd600;
        bus.pac_y = 9'd140;
        do_move(600, 140, 600, 140, 0, -1, "t4 capture move", 1'b0);
        chk("caught not yet", bus.caught, 0);
        @(negedge clk);
        chk("caught set", bus.caught, 1);
        ticks = 0;
        moved = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.move_tick) ticks++;
            if (bus.x != 10'd600 || bus.y != 9'd140) moved++;
        end
        chk("halt no ticks", ticks, 0);
        chk("halt frozen", moved, 0);

        // Respawn out of HALT.
        bus.pac_x = 10'd0;
        bus.pac_y = 9'd0;
        step();
        bus.respawn = 1'b1;
        step();
        bus.respawn = 1'b0;
        @(negedge clk);
        chk("halt respawn x", bus.x, 600);
        chk("halt respawn y", bus.y, 160);
        chk("halt respawn caught", bus.caught, 0);
        chk("halt respawn blocked", bus.blocked, 0);
        chk("halt respawn no tick", bus.move_tick, 0);
        cur_x = 600;
        cur_y = 160;

        // run dropped during CHECK: move still commits.
        do_move(580, 160, 580, 160, 0, 3, "t6 run drop", 1'b1);

        // Count to 2, hold 10 cycles with run=0, resume: tick after 2 more.
        step();
        bus.run = 1'b1;
        step();
        step();
        bus.run = 1'b0;
        ticks = 0;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.move_tick) ticks++;
            if (bus.x != 10'd580 || bus.y != 9'd160) moved++;
            step();
        end
        chk("run=0 no ticks", ticks, 0);
        chk("run=0 position held", moved, 0);
        bus.run = 1'b1;
        do_move(580, 180, 580, 180, 0, 2, "t6 resume", 1'b0);

        repeat (3) @(negedge clk);
        n = exp_q.size();
        chk("scoreboard drained", n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
